vmu_mem_arb: RTL and testbench
==============================

// Module: vmu_mem_arb
// PURPOSE
//  N-channel memory-request arbiter and response router for the vector memory unit; replaces fixed load-over-store muxing.
//  Round-robin arbitrates NUM_ENG engine request streams (load/store engines, gather/scatter) onto one cache port.
//  Prepends the engine ID to each ticket and tracks outstanding loads per engine with a credit limit.
//  Routes cache responses back to the engine named by the ticket's ID field.
// PARAMETERS
//  NUM_ENG        2   number of requesting engines (>=2)
//  ADDR_WIDTH     32  request address width
//  REQ_DATA_WIDTH 32  store data width
//  TICKET_W       4   per-engine ticket width
//  MAX_OUTST      8   max outstanding loads per engine (>=1)
//  ID_W = $clog2(NUM_ENG) (localparam); CNT_W = $clog2(MAX_OUTST+1) (localparam)
// PORTS
//  clk                 in   1                      clock
//  rst_n               in   1                      async active-low reset
//  eng_req_valid_i     in   NUM_ENG                per-engine request valid
//  eng_req_ready_o     out  NUM_ENG                per-engine request accepted (one-hot or zero)
//  eng_req_store_i     in   NUM_ENG                1=store (no response), 0=load
//  eng_req_addr_i      in   NUM_ENG*ADDR_WIDTH     per-engine address, engine g at [g*ADDR_WIDTH+:ADDR_WIDTH]
//  eng_req_data_i      in   NUM_ENG*REQ_DATA_WIDTH per-engine store data
//  eng_req_ticket_i    in   NUM_ENG*TICKET_W       per-engine ticket
//  mem_req_valid_o     out  1                      request to cache valid (registered)
//  mem_req_ready_i     in   1                      cache accepts request
//  mem_req_store_o     out  1                      store flag
//  mem_req_addr_o      out  ADDR_WIDTH             address
//  mem_req_data_o      out  REQ_DATA_WIDTH         store data
//  mem_req_ticket_o    out  ID_W+TICKET_W          {engine_id, engine ticket}
//  mem_resp_valid_i    in   1                      cache response valid (no backpressure)
//  mem_resp_ticket_i   in   ID_W+TICKET_W          response ticket
//  mem_resp_data_i     in   REQ_DATA_WIDTH         response data
//  eng_resp_valid_o    out  NUM_ENG                one-hot response strobe to owning engine
//  eng_resp_ticket_o   out  TICKET_W               response ticket, ID stripped (broadcast)
//  eng_resp_data_o     out  REQ_DATA_WIDTH         response data (broadcast)
//  outst_o             out  NUM_ENG*CNT_W          per-engine outstanding-load count
//  resp_err_o          out  1                      sticky: response with ID>=NUM_ENG or to engine with count 0
//  idle_o              out  1                      no outstanding loads, output reg empty, no valid request
// BEHAVIOUR
//  Reset (async, rst_n=0): mem_req_valid_o=0, all mem_req_* fields 0, rr pointer=0, all outst=0,
//   eng_resp_valid_o=0, eng_resp_ticket_o/data_o=0, resp_err_o=0; idle_o=1 once inputs are deasserted.
//  Eligible(g) = eng_req_valid_i[g] & (eng_req_store_i[g] | outst[g]<MAX_OUTST).
//  Output register load: load_ok = ~mem_req_valid_o | mem_req_ready_i (full throughput, 1 req/cycle).
//  Grant: first eligible engine at or after rr pointer, searching upward with wrap from NUM_ENG-1 to 0.
//   eng_req_ready_o[g] = grant[g] & load_ok (combinational; may depend on valid).
//  On accept of g: output reg <= engine g fields, ticket {g,ticket}; rr pointer <= (g+1) mod NUM_ENG.
//   Load accept: outst[g]++. Request-to-cache latency: 1 cycle.
//  mem_req_valid_o held with stable fields until mem_req_ready_i; cleared when ready and nothing accepted.
//  Response: registered, latency 1: eng_resp_valid_o[id]=1 next cycle, ticket=low TICKET_W bits, data passed.
//   Valid response to engine g: outst[g]--. Load accept + response for same g same cycle: count unchanged.
//  Error: ID>=NUM_ENG, or outst[id]==0 -> no strobe, no count change, resp_err_o<=1 until reset.
//  Counters saturate: never exceed MAX_OUTST (enforced by eligibility) and never wrap below 0.
//  Mid-operation reset: all in-flight state dropped; responses arriving later fall under the error rule.
//  Stores never change outst; store-only traffic never blocks on credits.
// TESTING
//  T1 reset: rst_n=0 with engines valid -> mem_req_valid_o=0, eng_req_ready_o=0, idle_o=0 (inputs valid), outst all 0.
//  T2 fairness: NUM_ENG=2, both valid every cycle, mem_req_ready_i=1 -> grants alternate 0,1,0,1; tickets {0,t},{1,t}.
//  T3 backpressure: mem_req_ready_i=0 for 3 cycles -> mem_req_* stable, eng_req_ready_o=0; accept resumes the cycle ready rises.
//  T4 credits: MAX_OUTST=8, engine0 issues 8 loads without responses -> ready0 stays 0 on 9th, stores from engine0 still accepted;
//   one response ticket {0,5} -> eng_resp_valid_o=01, eng_resp_ticket_o=5, outst0=7, 9th load issues.
//  T5 simultaneous: outst1=3, load accept and response for engine1 in same cycle -> outst1 stays 3.
//  T6 error: NUM_ENG=3, response with ID=3 -> eng_resp_valid_o=0, resp_err_o=1 and stays 1 until reset.

Source files
------------

// File: rtl/vmu_mem_arb_if.sv
// Bus bundle for the vector memory unit arbiter:
// engine request/response side plus the single cache port.
interface vmu_mem_arb_if #(
  parameter int NUM_ENG        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int REQ_DATA_WIDTH = 32,
  parameter int TICKET_W       = 4,
  parameter int MAX_OUTST      = 8
);
  localparam int ID_W  = $clog2(NUM_ENG);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [NUM_ENG-1:0]                eng_req_valid_i;
  logic [NUM_ENG-1:0]                eng_req_ready_o;
  logic [NUM_ENG-1:0]                eng_req_store_i;
  logic [NUM_ENG*ADDR_WIDTH-1:0]     eng_req_addr_i;
  logic [NUM_ENG*REQ_DATA_WIDTH-1:0] eng_req_data_i;
  logic [NUM_ENG*TICKET_W-1:0]       eng_req_ticket_i;

  logic                              mem_req_valid_o;
  logic                              mem_req_ready_i;
  logic                              mem_req_store_o;
  logic [ADDR_WIDTH-1:0]             mem_req_addr_o;
  logic [REQ_DATA_WIDTH-1:0]         mem_req_data_o;
  logic [ID_W+TICKET_W-1:0]          mem_req_ticket_o;

  logic                              mem_resp_valid_i;
  logic [ID_W+TICKET_W-1:0]          mem_resp_ticket_i;
  logic [REQ_DATA_WIDTH-1:0]         mem_resp_data_i;

  logic [NUM_ENG-1:0]                eng_resp_valid_o;
  logic [TICKET_W-1:0]               eng_resp_ticket_o;
  logic [REQ_DATA_WIDTH-1:0]         eng_resp_data_o;

  logic [NUM_ENG*CNT_W-1:0]          outst_o;
  logic                              resp_err_o;
  logic                              idle_o;

  modport slave (
    input  eng_req_valid_i, eng_req_store_i,
    input  eng_req_addr_i, eng_req_data_i,
    input  eng_req_ticket_i, mem_req_ready_i,
    input  mem_resp_valid_i, mem_resp_ticket_i,
    input  mem_resp_data_i,
    output eng_req_ready_o, mem_req_valid_o,
    output mem_req_store_o, mem_req_addr_o,
    output mem_req_data_o, mem_req_ticket_o,
    output eng_resp_valid_o, eng_resp_ticket_o,
    output eng_resp_data_o, outst_o,
    output resp_err_o, idle_o
  );

  modport master (
    output eng_req_valid_i, eng_req_store_i,
    output eng_req_addr_i, eng_req_data_i,
    output eng_req_ticket_i, mem_req_ready_i,
    output mem_resp_valid_i, mem_resp_ticket_i,
    output mem_resp_data_i,
    input  eng_req_ready_o, mem_req_valid_o,
    input  mem_req_store_o, mem_req_addr_o,
    input  mem_req_data_o, mem_req_ticket_o,
    input  eng_resp_valid_o, eng_resp_ticket_o,
    input  eng_resp_data_o, outst_o,
    input  resp_err_o, idle_o
  );
endinterface

// File: rtl/vmu_mem_arb.sv
// Round-robin arbiter of engine memory requests onto one cache
// port, with per-engine load credits and response routing.
module vmu_mem_arb #(
  parameter int NUM_ENG        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int REQ_DATA_WIDTH = 32,
  parameter int TICKET_W       = 4,
  parameter int MAX_OUTST      = 8
) (
  input logic          clk,
  input logic          rst_n,
  vmu_mem_arb_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_ENG);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [CNT_W-1:0]          outst [NUM_ENG];
  logic [ID_W-1:0]           rr;
  logic [NUM_ENG-1:0]        elig;
  logic [NUM_ENG-1:0]        grant;
  logic [NUM_ENG-1:0]        rdy;
  logic [NUM_ENG-1:0]        inc;
  logic [NUM_ENG-1:0]        hit;
  logic [ID_W-1:0]           gidx;
  logic                      found;
  logic                      load_ok;
  logic                      accept;
  logic                      bad;
  logic                      any_outst;
  logic [ID_W-1:0]           rid;
  logic                      sel_store;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [REQ_DATA_WIDTH-1:0] sel_data;
  logic [TICKET_W-1:0]       sel_ticket;

  logic                      req_valid;
  logic                      req_store;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [REQ_DATA_WIDTH-1:0] req_data;
  logic [ID_W+TICKET_W-1:0]  req_ticket;
  logic [NUM_ENG-1:0]        resp_valid;
  logic [TICKET_W-1:0]       resp_ticket;
  logic [REQ_DATA_WIDTH-1:0] resp_data;
  logic                      resp_err;

  always_comb begin
    elig      = '0;
    any_outst = 1'b0;
    for (int g = 0; g < NUM_ENG; g++) begin
      elig[g] = bus.eng_req_valid_i[g] &
                (bus.eng_req_store_i[g] |
                 (outst[g] < CNT_W'(MAX_OUTST)));
      any_outst = any_outst | (outst[g] != '0);
    end
  end

  // Search upward from rr, wrapping past the top engine.
  always_comb begin
    int j;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_ENG; i++) begin
      j = int'(rr) + i;
      if (j >= NUM_ENG) j = j - NUM_ENG;
      if (!found && elig[j]) begin
        found    = 1'b1;
        gidx     = ID_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_store  = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;
    sel_ticket = '0;
    for (int g = 0; g < NUM_ENG; g++) begin
      if (grant[g]) begin
        sel_store  = bus.eng_req_store_i[g];
        sel_addr   = bus.eng_req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = bus.eng_req_data_i[g*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
        sel_ticket = bus.eng_req_ticket_i[g*TICKET_W +: TICKET_W];
      end
    end
  end

  assign load_ok = ~req_valid | bus.mem_req_ready_i;
  assign rdy     = grant & {NUM_ENG{load_ok & rst_n}};
  assign accept  = |rdy;
  assign inc     = rdy & ~bus.eng_req_store_i;
  assign rid     = bus.mem_resp_ticket_i[TICKET_W +: ID_W];

  // A response only counts if its engine really has a load in flight.
  always_comb begin
    hit = '0;
    for (int g = 0; g < NUM_ENG; g++) begin
      hit[g] = bus.mem_resp_valid_i &
               (rid == ID_W'(g)) & (outst[g] != '0);
    end
  end

  assign bad = bus.mem_resp_valid_i & ~|hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid  <= 1'b0;
      req_store  <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      req_ticket <= '0;
      rr         <= '0;
    end else if (accept) begin
      req_valid  <= 1'b1;
      req_store  <= sel_store;
      req_addr   <= sel_addr;
      req_data   <= sel_data;
      req_ticket <= {gidx, sel_ticket};
      rr         <= (gidx == ID_W'(NUM_ENG - 1)) ? '0 : gidx + 1'b1;
    end else if (bus.mem_req_ready_i) begin
      req_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_ENG; g++) outst[g] <= '0;
    end else begin
      for (int g = 0; g < NUM_ENG; g++) begin
        unique case ({inc[g], hit[g]})
          2'b10:   outst[g] <= outst[g] + 1'b1;
          2'b01:   outst[g] <= outst[g] - 1'b1;
          default: outst[g] <= outst[g];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= '0;
      resp_ticket <= '0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
    end else begin
      resp_valid <= hit;
      if (bus.mem_resp_valid_i) begin
        resp_ticket <= bus.mem_resp_ticket_i[TICKET_W-1:0];
        resp_data   <= bus.mem_resp_data_i;
      end
      if (bad) resp_err <= 1'b1;
    end
  end

  always_comb begin
    bus.outst_o = '0;
    for (int g = 0; g < NUM_ENG; g++) begin
      bus.outst_o[g*CNT_W +: CNT_W] = outst[g];
    end
  end

  assign bus.eng_req_ready_o   = rdy;
  assign bus.mem_req_valid_o   = req_valid;
  assign bus.mem_req_store_o   = req_store;
  assign bus.mem_req_addr_o    = req_addr;
  assign bus.mem_req_data_o    = req_data;
  assign bus.mem_req_ticket_o  = req_ticket;
  assign bus.eng_resp_valid_o  = resp_valid;
  assign bus.eng_resp_ticket_o = resp_ticket;
  assign bus.eng_resp_data_o   = resp_data;
  assign bus.resp_err_o        = resp_err;
  assign bus.idle_o = ~any_outst & ~req_valid &
                      ~|bus.eng_req_valid_i;
endmodule

// File: tb/tb_vmu_mem_arb.sv
// Directed bench for vmu_mem_arb: a 2-engine and a 3-engine
// instance driven with hand-computed vectors.
module tb_vmu_mem_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vmu_mem_arb_if #(.NUM_ENG(2)) bus2 ();
  vmu_mem_arb_if #(.NUM_ENG(3)) bus3 ();

  vmu_mem_arb #(.NUM_ENG(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );
  vmu_mem_arb #(.NUM_ENG(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus2.eng_req_valid_i   = '0;
    bus2.eng_req_store_i   = '0;
    bus2.eng_req_addr_i    = {32'h0000_0200, 32'h0000_0100};
    bus2.eng_req_data_i    = {32'hBBBB_0002, 32'hAAAA_0001};
    bus2.eng_req_ticket_i  = {4'h9, 4'h3};
    bus2.mem_req_ready_i   = 1'b1;
    bus2.mem_resp_valid_i  = 1'b0;
    bus2.mem_resp_ticket_i = '0;
    bus2.mem_resp_data_i   = '0;
    bus3.eng_req_valid_i   = '0;
    bus3.eng_req_store_i   = '0;
    bus3.eng_req_addr_i    = {32'h300, 32'h200, 32'h100};
    bus3.eng_req_data_i    = '0;
    bus3.eng_req_ticket_i  = {4'hC, 4'hB, 4'hA};
    bus3.mem_req_ready_i   = 1'b1;
    bus3.mem_resp_valid_i  = 1'b0;
    bus3.mem_resp_ticket_i = '0;
    bus3.mem_resp_data_i   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    #1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus2.eng_req_valid_i = 2'b11;
    #2;
    checks++;
    if (bus2.mem_req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b exp 0", bus2.mem_req_valid_o);
    end
    checks++;
    if (bus2.eng_req_ready_o !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready got %b exp 00", bus2.eng_req_ready_o);
    end
    checks++;
    if (bus2.idle_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_busy got %b exp 0", bus2.idle_o);
    end
    checks++;
    if (bus2.outst_o !== 8'h00 || bus2.mem_req_ticket_o !== 5'h00) begin
      errors++;
      $display("FAIL rst_state got outst %h tkt %h exp 00 00",
               bus2.outst_o, bus2.mem_req_ticket_o);
    end
    checks++;
    if (bus2.resp_err_o !== 1'b0 || bus2.eng_resp_valid_o !== 2'b00) begin
      errors++;
      $display("FAIL rst_resp got err %b rv %b exp 0 00",
               bus2.resp_err_o, bus2.eng_resp_valid_o);
    end
    bus2.eng_req_valid_i = 2'b00;
    #1;
    checks++;
    if (bus2.idle_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle got %b exp 1", bus2.idle_o);
    end
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fairness();
    logic [1:0] er;
    logic [4:0] et;
    logic [31:0] ea;
    do_reset();
    bus2.eng_req_valid_i = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      er = (k % 2 == 0) ? 2'b01 : 2'b10;
      et = (k % 2 == 0) ? 5'h03 : 5'h19;
      ea = (k % 2 == 0) ? 32'h100 : 32'h200;
      checks++;
      if (bus2.eng_req_ready_o !== er) begin
        errors++;
        $display("FAIL rr_grant%0d got %b exp %b", k,
                 bus2.eng_req_ready_o, er);
      end
      step();
      checks++;
      if (bus2.mem_req_valid_o !== 1'b1 || bus2.mem_req_ticket_o !== et ||
          bus2.mem_req_addr_o !== ea) begin
        errors++;
        $display("FAIL rr_req%0d got v%b t%h a%h exp v1 t%h a%h", k,
                 bus2.mem_req_valid_o, bus2.mem_req_ticket_o,
                 bus2.mem_req_addr_o, et, ea);
      end
    end
    bus2.eng_req_valid_i = 2'b00;
    step();
    checks++;
    if (bus2.mem_req_valid_o !== 1'b0 || bus2.outst_o !== 8'h22) begin
      errors++;
      $display("FAIL rr_drain got v%b outst %h exp v0 22",
               bus2.mem_req_valid_o, bus2.outst_o);
    end
    checks++;
    if (bus2.idle_o !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle got %b exp 0", bus2.idle_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus2.eng_req_valid_i = 2'b01;
    bus2.eng_req_ticket_i = {4'h9, 4'h1};
    step();
    bus2.mem_req_ready_i = 1'b0;
    bus2.eng_req_valid_i = 2'b10;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus2.eng_req_ready_o !== 2'b00 || bus2.mem_req_valid_o !== 1'b1 ||
          bus2.mem_req_addr_o !== 32'h100 ||
          bus2.mem_req_ticket_o !== 5'h01) begin
        errors++;
        $display("FAIL bp_hold%0d got r%b v%b a%h t%h exp r00 v1 a100 t01",
                 k, bus2.eng_req_ready_o, bus2.mem_req_valid_o,
                 bus2.mem_req_addr_o, bus2.mem_req_ticket_o);
      end
      step();
    end
    bus2.mem_req_ready_i = 1'b1;
    #1;
    checks++;
    if (bus2.eng_req_ready_o !== 2'b10) begin
      errors++;
      $display("FAIL bp_resume got %b exp 10", bus2.eng_req_ready_o);
    end
    step();
    checks++;
    if (bus2.mem_req_addr_o !== 32'h200 || bus2.mem_req_ticket_o !== 5'h19) begin
      errors++;
      $display("FAIL bp_next got a%h t%h exp a200 t19",
               bus2.mem_req_addr_o, bus2.mem_req_ticket_o);
    end
  endtask

  task automatic test_credits();
    do_reset();
    bus2.eng_req_valid_i = 2'b01;
    bus2.eng_req_ticket_i = {4'h9, 4'hA};
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (bus2.outst_o[3:0] !== 4'd8 || bus2.eng_req_ready_o !== 2'b00) begin
      errors++;
      $display("FAIL cr_full got outst %0d r%b exp 8 r00",
               bus2.outst_o[3:0], bus2.eng_req_ready_o);
    end
    bus2.eng_req_store_i = 2'b01;
    #1;
    checks++;
    if (bus2.eng_req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL cr_store_rdy got %b exp 01", bus2.eng_req_ready_o);
    end
    step();
    checks++;
    if (bus2.mem_req_store_o !== 1'b1 || bus2.outst_o[3:0] !== 4'd8) begin
      errors++;
      $display("FAIL cr_store got s%b outst %0d exp s1 8",
               bus2.mem_req_store_o, bus2.outst_o[3:0]);
    end
    bus2.eng_req_store_i   = 2'b00;
    bus2.mem_resp_valid_i  = 1'b1;
    bus2.mem_resp_ticket_i = 5'h05;
    bus2.mem_resp_data_i   = 32'hCAFE_0005;
    step();
    bus2.mem_resp_valid_i = 1'b0;
    #1;
    checks++;
    if (bus2.eng_resp_valid_o !== 2'b01 || bus2.eng_resp_ticket_o !== 4'h5 ||
        bus2.eng_resp_data_o !== 32'hCAFE_0005) begin
      errors++;
      $display("FAIL cr_resp got v%b t%h d%h exp v01 t5 dcafe0005",
               bus2.eng_resp_valid_o, bus2.eng_resp_ticket_o,
               bus2.eng_resp_data_o);
    end
    checks++;
    if (bus2.outst_o[3:0] !== 4'd7 || bus2.eng_req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL cr_release got outst %0d r%b exp 7 r01",
               bus2.outst_o[3:0], bus2.eng_req_ready_o);
    end
    step();
    checks++;
    if (bus2.outst_o[3:0] !== 4'd8 || bus2.mem_req_store_o !== 1'b0 ||
        bus2.eng_resp_valid_o !== 2'b00) begin
      errors++;
      $display("FAIL cr_ninth got outst %0d s%b rv%b exp 8 s0 rv00",
               bus2.outst_o[3:0], bus2.mem_req_store_o,
               bus2.eng_resp_valid_o);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus2.eng_req_valid_i = 2'b10;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (bus2.outst_o[7:4] !== 4'd3) begin
      errors++;
      $display("FAIL sim_pre got %0d exp 3", bus2.outst_o[7:4]);
    end
    bus2.mem_resp_valid_i  = 1'b1;
    bus2.mem_resp_ticket_i = 5'h12;
    step();
    bus2.mem_resp_valid_i = 1'b0;
    bus2.eng_req_valid_i  = 2'b00;
    #1;
    checks++;
    if (bus2.outst_o[7:4] !== 4'd3 || bus2.eng_resp_valid_o !== 2'b10 ||
        bus2.eng_resp_ticket_o !== 4'h2) begin
      errors++;
      $display("FAIL sim_same got outst %0d rv%b t%h exp 3 rv10 t2",
               bus2.outst_o[7:4], bus2.eng_resp_valid_o,
               bus2.eng_resp_ticket_o);
    end
  endtask

  task automatic test_zero_credit_err();
    do_reset();
    bus2.mem_resp_valid_i  = 1'b1;
    bus2.mem_resp_ticket_i = 5'h01;
    step();
    bus2.mem_resp_valid_i = 1'b0;
    #1;
    checks++;
    if (bus2.eng_resp_valid_o !== 2'b00 || bus2.resp_err_o !== 1'b1 ||
        bus2.outst_o !== 8'h00) begin
      errors++;
      $display("FAIL zc_err got rv%b err%b outst %h exp rv00 err1 00",
               bus2.eng_resp_valid_o, bus2.resp_err_o, bus2.outst_o);
    end
  endtask

  task automatic test_three_eng();
    logic [5:0] t;
    logic [1:0] ids [4];
    ids = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    bus3.eng_req_valid_i = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      t = bus3.mem_req_ticket_o;
      checks++;
      if (t[5:4] !== ids[k]) begin
        errors++;
        $display("FAIL e3_grant%0d got id %0d exp %0d", k, t[5:4], ids[k]);
      end
    end
    bus3.eng_req_valid_i = 3'b000;
    step();
  endtask

  task automatic test_error();
    do_reset();
    bus3.mem_resp_valid_i  = 1'b1;
    bus3.mem_resp_ticket_i = 6'h37;
    step();
    bus3.mem_resp_valid_i = 1'b0;
    #1;
    checks++;
    if (bus3.eng_resp_valid_o !== 3'b000 || bus3.resp_err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_id got rv%b err%b exp rv000 err1",
               bus3.eng_resp_valid_o, bus3.resp_err_o);
    end
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (bus3.resp_err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b exp 1", bus3.resp_err_o);
    end
    do_reset();
    checks++;
    if (bus3.resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b exp 0", bus3.resp_err_o);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_backpressure();
    test_credits();
    test_simultaneous();
    test_zero_credit_err();
    test_three_eng();
    test_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
